// File: rtl/led_sched_pkg.sv
// led_sched_pkg: shared types and helpers for the LED bank scheduler.
// Holds the FSM state enum, default bank geometry and a one-hot helper.
package led_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int LED_NLED  = 5;
    localparam int LED_PWM_W = 2;
    localparam int MAX_REQ   = 8;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/led_sched_if.sv
// led_sched_if: requester-side and LED-side signals of the scheduler.
// master: requesters/pins side (drives REQ*); slave: scheduler (drives GNT, BUSY, LED).
interface led_sched_if
    import led_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NLED  = LED_NLED,
    parameter int PWM_W = LED_PWM_W
);
    logic [NREQ-1:0]       REQ;
    logic [NREQ*NLED-1:0]  REQ_PAT;
    logic [NREQ*PWM_W-1:0] REQ_LVL;
    logic [NREQ-1:0]       GNT;
    logic                  BUSY;
    logic [NLED-1:0]       LED;

    modport master (
        output REQ, REQ_PAT, REQ_LVL,
        input  GNT, BUSY, LED
    );

    modport slave (
        input  REQ, REQ_PAT, REQ_LVL,
        output GNT, BUSY, LED
    );
endinterface

// File: rtl/led_rr_arb.sv
// led_rr_arb: combinational round-robin picker.
// Ports: req (request vector), ptr (last winner) -> valid, winner (first set after ptr).
module led_rr_arb #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);
    int               idx;
    logic [IDX_W-1:0] idx_w;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_w  = '0;
        // Scan ptr+1 .. ptr+NREQ so the previous winner is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            idx   = (int'(ptr) + k) % NREQ;
            idx_w = IDX_W'(idx);
            if (!valid && req[idx_w]) begin
                valid  = 1'b1;
                winner = idx_w;
            end
        end
    end
endmodule

// File: rtl/led_sched.sv
// led_sched: time-shares an LED bank between NREQ requesters (round-robin,
// minimum hold, blank gap, PWM brightness). Ports: CLK, RST_N (sync, active
// low), bus (led_sched_if.slave). Optional macro LED_SCHED_PREEMPT_EN lets
// requester 0 take the bank mid-SHOW without a gap.
module led_sched
    import led_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int NLED     = LED_NLED,
    parameter int PWM_W    = LED_PWM_W,
    parameter int HOLD_CYC = 4194304,
    parameter int GAP_CYC  = 131072
) (
    input logic        CLK,
    input logic        RST_N,
    led_sched_if.slave bus
);
    localparam int IDX_W  = $clog2(NREQ);
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_LD  = GAP_W'(GAP_CYC - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [PWM_W-1:0]   pwm_q, pwm_d;
    logic [NLED-1:0]    pat_q, pat_d;
    logic [PWM_W-1:0]   lvl_q, lvl_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic [NLED-1:0]    led_q, led_d;

    logic               arb_valid;
    logic [IDX_W-1:0]   arb_win;
    logic [MAX_REQ-1:0] own_oh, nxt_oh;
    logic               others;
    logic               preempt;
    logic [NLED-1:0]    lit;

    led_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (bus.REQ),
        .ptr    (ptr_q),
        .valid  (arb_valid),
        .winner (arb_win)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        pat_d   = pat_q;
        lvl_d   = lvl_q;
        led_d   = '0;
        pwm_d   = pwm_q + PWM_W'(1);

        own_oh = onehot(3'(owner_q));
        others = |(bus.REQ & ~own_oh[NREQ-1:0]);
        lit    = pat_q & {NLED{pwm_q <= lvl_q}};
`ifdef LED_SCHED_PREEMPT_EN
        preempt = bus.REQ[0] && (owner_q != '0);
`else
        preempt = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = SHOW;
                    owner_d = arb_win;
                    ptr_d   = arb_win;
                    hold_d  = HOLD_LD;
                    pat_d   = bus.REQ_PAT[int'(arb_win)*NLED +: NLED];
                    lvl_d   = bus.REQ_LVL[int'(arb_win)*PWM_W +: PWM_W];
                end
            end
            SHOW: begin
                led_d = lit;
                if (preempt) begin
                    // Direct hand-over to requester 0, no blank gap.
                    owner_d = '0;
                    ptr_d   = '0;
                    hold_d  = HOLD_LD;
                    pat_d   = bus.REQ_PAT[NLED-1:0];
                    lvl_d   = bus.REQ_LVL[PWM_W-1:0];
                end else if (!bus.REQ[owner_q] ||
                             (hold_q == '0 && others)) begin
                    state_d = GAP;
                    gap_d   = GAP_LD;
                    led_d   = '0;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
                    // Sole requester at expiry: extend, snapshot kept.
                    hold_d = HOLD_LD;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        nxt_oh = onehot(3'(owner_d));
        gnt_d  = (state_d == SHOW) ? nxt_oh[NREQ-1:0] : '0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NREQ - 1);
            hold_q  <= '0;
            gap_q   <= '0;
            pwm_q   <= '0;
            pat_q   <= '0;
            lvl_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            pwm_q   <= pwm_d;
            pat_q   <= pat_d;
            lvl_q   <= lvl_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
        end
    end

    assign bus.GNT  = gnt_q;
    assign bus.BUSY = busy_q;
    assign bus.LED  = led_q;
endmodule

// File: tb/tb_led_sched.sv
// tb_led_sched: directed bench for led_sched (HOLD_CYC=8, GAP_CYC=2, NREQ=4).
// Optional macro LED_SCHED_PREEMPT_EN selects the preemption expectations.
module tb_led_sched;
    import led_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int NLED = 5;
    localparam int PW   = 2;

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;
    int   ones;
    int   bad;

    logic [NLED-1:0] p0, p1, p2, p3;
    logic [NLED-1:0] pats [4];

    led_sched_if #(.NREQ(NREQ), .NLED(NLED), .PWM_W(PW)) bus ();

    led_sched #(
        .NREQ     (NREQ),
        .NLED     (NLED),
        .PWM_W    (PW),
        .HOLD_CYC (8),
        .GAP_CYC  (2)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic count_led(input logic [NLED-1:0] on_pat);
        ones = 0;
        bad  = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.LED === on_pat) ones++;
            else if (bus.LED !== '0) bad++;
            chk("pwm_gnt", 32'(bus.GNT), 32'h2);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        p0 = 5'b00111;
        p1 = 5'b11000;
        p2 = 5'b10101;
        p3 = 5'b01010;
        pats[0] = p0;
        pats[1] = p1;
        pats[2] = p2;
        pats[3] = p3;

        RST_N       = 1'b0;
        bus.REQ     = '0;
        bus.REQ_PAT = {p3, p2, p1, p0};
        bus.REQ_LVL = 8'hFF;
        tick();
        tick();
        chk("rst_gnt", 32'(bus.GNT), 32'h0);
        chk("rst_led", 32'(bus.LED), 32'h0);
        chk("rst_busy", 32'(bus.BUSY), 32'h0);
        RST_N = 1'b1;
        tick();
        chk("idle_gnt", 32'(bus.GNT), 32'h0);

        // Single requester 2: grant at t+1, pattern at t+2, extension.
        bus.REQ = 4'b0100;
        tick();
        chk("g2_gnt", 32'(bus.GNT), 32'h4);
        chk("g2_led0", 32'(bus.LED), 32'h0);
        chk("g2_busy", 32'(bus.BUSY), 32'h1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("ext_gnt", 32'(bus.GNT), 32'h4);
            chk("ext_led", 32'(bus.LED), 32'h15);
            chk("ext_busy", 32'(bus.BUSY), 32'h1);
        end

        // Reset mid-SHOW, then all requesting: requester 0 first.
        RST_N   = 1'b0;
        bus.REQ = 4'b1111;
        tick();
        chk("mrst_gnt", 32'(bus.GNT), 32'h0);
        chk("mrst_led", 32'(bus.LED), 32'h0);
        chk("mrst_busy", 32'(bus.BUSY), 32'h0);
        RST_N = 1'b1;
        tick();

        // Round-robin 0,1,2,3 with 8-cycle SHOW, 2 GAP, 1 IDLE.
        for (int g = 0; g < 4; g++) begin
            chk("rr_gnt", 32'(bus.GNT), 32'(1 << g));
            for (int k = 1; k < 8; k++) begin
                tick();
                chk("rr_hold", 32'(bus.GNT), 32'(1 << g));
                chk("rr_led", 32'(bus.LED), 32'(pats[g]));
                chk("rr_busy", 32'(bus.BUSY), 32'h1);
            end
`ifdef LED_SCHED_PREEMPT_EN
            if (g == 0) bus.REQ = 4'b1110;
`endif
            tick();
            chk("gap1_gnt", 32'(bus.GNT), 32'h0);
            chk("gap1_led", 32'(bus.LED), 32'h0);
            chk("gap1_busy", 32'(bus.BUSY), 32'h1);
            tick();
            chk("gap2_gnt", 32'(bus.GNT), 32'h0);
            chk("gap2_led", 32'(bus.LED), 32'h0);
            chk("gap2_busy", 32'(bus.BUSY), 32'h1);
            tick();
            chk("rr_idle_gnt", 32'(bus.GNT), 32'h0);
            chk("rr_idle_busy", 32'(bus.BUSY), 32'h0);
            if (g < 3) tick();
        end

        // Owner 1, lvl=0: lit 1 cycle in 4.
        bus.REQ     = 4'b0010;
        bus.REQ_PAT = {p3, p2, 5'b11111, p0};
        bus.REQ_LVL = 8'b11_11_00_11;
        tick();
        chk("pwm_grant", 32'(bus.GNT), 32'h2);
        tick();
        count_led(5'b11111);
        chk("lvl0_on", 32'(ones), 32'd4);
        chk("lvl0_bad", 32'(bad), 32'd0);

        // Inputs changed mid-SHOW are ignored.
        bus.REQ_PAT = {p3, p2, 5'b00000, p0};
        bus.REQ_LVL = 8'b11_11_11_11;
        count_led(5'b11111);
        chk("snap_on", 32'(ones), 32'd4);
        chk("snap_bad", 32'(bad), 32'd0);

        bus.REQ = 4'b0000;
        tick();
        chk("rel_gnt", 32'(bus.GNT), 32'h0);
        chk("rel_led", 32'(bus.LED), 32'h0);
        tick();
        tick();
        chk("rel_idle", 32'(bus.BUSY), 32'h0);

        // Owner 1, lvl=2: lit 3 cycles in 4.
        bus.REQ     = 4'b0010;
        bus.REQ_PAT = {p3, p2, 5'b11111, p0};
        bus.REQ_LVL = 8'b11_11_10_11;
        tick();
        chk("pwm2_grant", 32'(bus.GNT), 32'h2);
        tick();
        count_led(5'b11111);
        chk("lvl2_on", 32'(ones), 32'd12);
        chk("lvl2_bad", 32'(bad), 32'd0);

        bus.REQ = 4'b0000;
        tick();
        tick();
        tick();
        chk("pre_er_idle", 32'(bus.BUSY), 32'h0);

        // Early release 3 cycles into SHOW.
        bus.REQ = 4'b0010;
        tick();
        chk("er_grant", 32'(bus.GNT), 32'h2);
        tick();
        tick();
        bus.REQ = 4'b0000;
        tick();
        chk("er_gnt", 32'(bus.GNT), 32'h0);
        chk("er_led", 32'(bus.LED), 32'h0);
        chk("er_busy", 32'(bus.BUSY), 32'h1);
        tick();
        chk("er_gap2", 32'(bus.BUSY), 32'h1);
        tick();
        chk("er_idle", 32'(bus.BUSY), 32'h0);
        chk("er_idle_gnt", 32'(bus.GNT), 32'h0);

        // Owner 2, then requester 0 rises.
        bus.REQ_PAT = {p3, p2, p1, p0};
        bus.REQ_LVL = 8'hFF;
        bus.REQ     = 4'b0100;
        tick();
        chk("pe_grant", 32'(bus.GNT), 32'h4);
        tick();
        tick();
        bus.REQ = 4'b0101;
        tick();
`ifdef LED_SCHED_PREEMPT_EN
        chk("pe_switch", 32'(bus.GNT), 32'h1);
        chk("pe_busy", 32'(bus.BUSY), 32'h1);
        tick();
        chk("pe_after", 32'(bus.GNT), 32'h1);
        chk("pe_led", 32'(bus.LED), 32'(p0));
`else
        chk("np_keep", 32'(bus.GNT), 32'h4);
        for (int k = 4; k < 8; k++) begin
            tick();
            chk("np_keep", 32'(bus.GNT), 32'h4);
        end
        tick();
        chk("np_gap1", 32'(bus.GNT), 32'h0);
        tick();
        chk("np_gap2", 32'(bus.GNT), 32'h0);
        tick();
        chk("np_idle", 32'(bus.BUSY), 32'h0);
        tick();
        chk("np_req0", 32'(bus.GNT), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
